// File: rtl/qenc_pkg.sv
// rtl/qenc_pkg.sv - quadrature state encoding, step enum and step decoder
package qenc_pkg;

  // Quadrature states as {a, b}; forward (A leads) order is 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  typedef enum logic [1:0] {HOLD, INC, DEC, ILLEGAL} step_e;

  // Classify the move from prev to cur: no change, one step either way, or both bits flipped
  function automatic step_e step_decode(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    s = HOLD;
    if (prev == cur) begin
      s = HOLD;
    end else if ((prev ^ cur) == 2'b11) begin
      s = ILLEGAL;
    end else begin
      case (prev)
        QS_00:   s = (cur == QS_10) ? INC : DEC;
        QS_10:   s = (cur == QS_11) ? INC : DEC;
        QS_11:   s = (cur == QS_01) ? INC : DEC;
        default: s = (cur == QS_00) ? INC : DEC;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/qenc_channel.sv
// rtl/qenc_channel.sv - one quadrature channel: sync, glitch filter, decode, position/dir/err
module qenc_channel #(
  parameter int CNT_W    = 12,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] ppr,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr_err,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             err
);
  import qenc_pkg::*;

  localparam logic [3:0] FCNT_LAST = 4'(FILT_LEN - 1);
  // prev is slaved to the filtered level until the sync/filter pipeline has refilled
  // after reset, so the first real sample only initialises it
  localparam logic [4:0] WARM_LAST = 5'(FILT_LEN + 2);

  logic [1:0]       sync1_q, sync2_q, filt_q, prev_q;
  logic [1:0][3:0]  fcnt_q;
  logic [4:0]       warm_q;
  logic             primed_q;
  logic [CNT_W-1:0] pos_q, pos_d, ppr_m1;
  logic             dir_q, dir_d, err_q, err_d, ppr_small;
  step_e            step;

  // Two-flop synchroniser for {a, b}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {qa, qb};
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after FILT_LEN consecutive samples that differ from the current one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] == filt_q[b]) begin
          fcnt_q[b] <= '0;
        end else if (fcnt_q[b] == FCNT_LAST) begin
          filt_q[b] <= sync2_q[b];
          fcnt_q[b] <= '0;
        end else begin
          fcnt_q[b] <= fcnt_q[b] + 4'd1;
        end
      end
    end
  end

  assign ppr_small = (ppr < CNT_W'(2));
  assign ppr_m1    = ppr - 1'b1;

  // Next position/dir/err from the decoded step; a new error beats a same-cycle clear
  always_comb begin
    step  = step_decode(prev_q, filt_q);
    pos_d = pos_q;
    dir_d = dir_q;
    err_d = clr_err ? 1'b0 : err_q;
    if (primed_q) begin
      case (step)
        INC: begin
          dir_d = 1'b1;
          if (ppr_small || pos_q >= ppr_m1) pos_d = '0;
          else                              pos_d = pos_q + 1'b1;
        end
        DEC: begin
          dir_d = 1'b0;
          if (ppr_small)                        pos_d = '0;
          else if (pos_q == '0 || pos_q >= ppr) pos_d = ppr_m1;
          else                                  pos_d = pos_q - 1'b1;
        end
        ILLEGAL: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Decode state: previous level, warm-up, and the counted outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      warm_q   <= '0;
      primed_q <= 1'b0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q <= filt_q;
      if (!primed_q) begin
        if (warm_q == WARM_LAST) primed_q <= 1'b1;
        else                     warm_q   <= warm_q + 5'd1;
      end
      pos_q <= pos_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;
  assign err = err_q;

endmodule

// File: rtl/qenc_pwm_bank.sv
// rtl/qenc_pwm_bank.sv - bank of quadrature decoders with position-proportional PWM outputs
module qenc_pwm_bank #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 12,
  parameter int FILT_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     ppr,
  input  logic [2:0]           rate,
  input  logic [NCH-1:0]       qa,
  input  logic [NCH-1:0]       qb,
  input  logic                 clr_err,
  output logic [NCH*CNT_W-1:0] pos,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       err,
  output logic [NCH-1:0]       pwm
);
  import qenc_pkg::*;

  logic [6:0]                  presc_q, presc_last;
  logic [CNT_W-1:0]            ramp_q;
  logic [NCH-1:0][CNT_W-1:0]   duty_q;
  logic [NCH-1:0]              pwm_q;
  logic                        tick, wrap;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    qenc_channel #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .ppr     (ppr),
      .qa      (qa[i]),
      .qb      (qb[i]),
      .clr_err (clr_err),
      .pos     (pos[i*CNT_W +: CNT_W]),
      .dir     (dir[i]),
      .err     (err[i])
    );
  end

  // Terminal count compares with >= so a rate lowered mid-count ticks at once instead of rolling over
  assign presc_last = 7'((8'd1 << rate) - 8'd1);
  assign tick       = (presc_q >= presc_last);
  assign wrap       = (ppr < CNT_W'(2)) || (ramp_q >= ppr - 1'b1);

  // Prescaler, ramp, and duty capture at frame boundaries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      ramp_q  <= '0;
      duty_q  <= '0;
    end else begin
      presc_q <= tick ? 7'd0 : presc_q + 7'd1;
      if (tick) begin
        if (wrap) begin
          ramp_q <= '0;
          for (int i = 0; i < NCH; i++) duty_q[i] <= pos[i*CNT_W +: CNT_W];
        end else begin
          ramp_q <= ramp_q + 1'b1;
        end
      end
    end
  end

  // Registered PWM compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) pwm_q[i] <= (ramp_q < duty_q[i]);
    end
  end

  assign pwm = pwm_q;

endmodule
